// File: rtl/pipe_gap_gen_if.sv
// rtl/pipe_gap_gen_if.sv - control and result bundle between game logic and the gap generator
interface pipe_gap_gen_if #(
  parameter int YW = 10,
  parameter int LW = 3
);
  logic          enable;
  logic [31:0]   rand_in;
  logic          pop;
  logic          gap_valid;
  logic [YW-1:0] gap_y;
  logic [LW-1:0] level;
  logic [15:0]   reject_cnt;

  modport master (
    output enable, rand_in, pop,
    input  gap_valid, gap_y, level, reject_cnt
  );

  modport slave (
    input  enable, rand_in, pop,
    output gap_valid, gap_y, level, reject_cnt
  );
endinterface

// File: rtl/pipe_gap_gen.sv
// rtl/pipe_gap_gen.sv - rejection-sampled, step-clamped pipe gap Y positions queued in a small FIFO
module pipe_gap_gen #(
  parameter int GAP_MIN   = 80,
  parameter int GAP_RANGE = 320,
  parameter int MAX_STEP  = 120,
  parameter int DEPTH     = 4,
  parameter int YW        = 10
) (
  input logic            i_clk,
  input logic            i_rst,
  pipe_gap_gen_if.slave  bus
);
  localparam int CW = $clog2(GAP_RANGE);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          r_s1_valid;
  logic [YW-1:0] r_s1_y;
  logic          r_first;
  logic [YW-1:0] r_last;
  logic [YW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_reject_cnt;

  logic [CW-1:0] w_cand;
  logic          w_room;
  logic          w_sample;
  logic          w_accept;
  logic [YW:0]   w_s1_x;
  logic [YW:0]   w_last_x;
  logic [YW:0]   w_hi;
  logic [YW:0]   w_s1_hi;
  logic [YW-1:0] w_push_y;
  logic          w_push;
  logic          w_pop;

  assign w_cand   = bus.rand_in[CW-1:0];
  // Room check uses registered state only, so one in-flight sample is always accounted for.
  assign w_room   = ({1'b0, r_level} + (LW+1)'(r_s1_valid)) < (LW+1)'(DEPTH);
  assign w_sample = bus.enable && w_room;
  assign w_accept = {1'b0, w_cand} < (CW+1)'(GAP_RANGE);

  assign w_s1_x   = {1'b0, r_s1_y};
  assign w_last_x = {1'b0, r_last};
  assign w_hi     = w_last_x + (YW+1)'(MAX_STEP);
  assign w_s1_hi  = w_s1_x + (YW+1)'(MAX_STEP);

  always_comb begin
    w_push_y = r_s1_y;
    if (!r_first) begin
      if (w_s1_x > w_hi)
        w_push_y = w_hi[YW-1:0];
      else if (w_s1_hi < w_last_x)
        w_push_y = r_last - YW'(MAX_STEP);
    end
  end

  assign w_push = r_s1_valid;
  assign w_pop  = bus.pop && (r_level != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_y       <= '0;
      r_first      <= 1'b1;
      r_last       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_reject_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_s1_valid <= w_sample && w_accept;
      if (w_sample && w_accept)
        r_s1_y <= YW'(GAP_MIN) + YW'(w_cand);
      if (w_sample && !w_accept && r_reject_cnt != 16'hFFFF)
        r_reject_cnt <= r_reject_cnt + 16'd1;

      if (w_push) begin
        r_mem[r_wptr] <= w_push_y;
        r_wptr        <= r_wptr + AW'(1);
        r_last        <= w_push_y;
        r_first       <= 1'b0;
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.gap_valid  = (r_level != '0);
  assign bus.gap_y      = r_mem[r_rptr];
  assign bus.level      = r_level;
  assign bus.reject_cnt = r_reject_cnt;
endmodule

// File: tb/tb_pipe_gap_gen.sv
// tb/tb_pipe_gap_gen.sv - directed and randomized checks of the pipe gap generator
module tb_pipe_gap_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pipe_gap_gen_if bus ();

  pipe_gap_gen dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int prev_y;
  int y;
  int diff;
  int guard;

  initial begin
    bus.enable  = 1'b0;
    bus.rand_in = '0;
    bus.pop     = 1'b0;

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_valid", bus.gap_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_rej",   bus.reject_cnt, 0);
    chk("rst_gapy",  bus.gap_y, 0);

    // constant rand 5: two-cycle latency, fill to DEPTH and hold
    bus.enable = 1'b1; bus.rand_in = 32'd5;
    tick();
    chk("lat_valid1", bus.gap_valid, 0);
    tick();
    chk("lat_valid2", bus.gap_valid, 1);
    chk("lat_gapy",   bus.gap_y, 85);
    chk("lat_level",  bus.level, 1);
    tick(3);
    chk("fill_level", bus.level, 4);
    tick(5);
    chk("hold_level", bus.level, 4);

    // all rejects
    rst = 1'b1; tick(); rst = 1'b0;
    bus.rand_in = 32'h0000_0190;
    tick(10);
    bus.enable = 1'b0;
    tick();
    chk("rej_cnt",   bus.reject_cnt, 10);
    chk("rej_level", bus.level, 0);
    chk("rej_valid", bus.gap_valid, 0);

    // clamping sequence 85, 380->205, 80->85
    rst = 1'b1; tick(); rst = 1'b0;
    bus.enable = 1'b1;
    bus.rand_in = 32'd5;   tick();
    bus.rand_in = 32'd300; tick();
    bus.rand_in = 32'd0;   tick();
    bus.enable = 1'b0;
    tick(3);
    chk("clamp_level", bus.level, 3);
    chk("clamp_e0", bus.gap_y, 85);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("clamp_e1", bus.gap_y, 205);
    chk("clamp_lvl2", bus.level, 2);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("clamp_e2", bus.gap_y, 85);
    chk("clamp_lvl1", bus.level, 1);

    // full FIFO, pop, refill, simultaneous push+pop
    rst = 1'b1; tick(); rst = 1'b0;
    bus.enable = 1'b1;
    bus.rand_in = 32'd5;   tick();
    bus.rand_in = 32'd100; tick();
    bus.rand_in = 32'd200; tick();
    bus.rand_in = 32'd250; tick();
    bus.rand_in = 32'd0;
    tick(2);
    chk("full_level", bus.level, 4);
    chk("full_head",  bus.gap_y, 85);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("pop_level", bus.level, 3);
    chk("pop_head",  bus.gap_y, 180);
    tick();
    chk("refill_wait", bus.level, 3);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    bus.enable = 1'b0;
    chk("pushpop_level", bus.level, 3);
    chk("pushpop_head",  bus.gap_y, 280);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("drain_330", bus.gap_y, 330);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("drain_210", bus.gap_y, 210);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("drain_level", bus.level, 0);

    // pop on empty is ignored
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("empty_pop_level", bus.level, 0);
    chk("empty_pop_valid", bus.gap_valid, 0);

    // random traffic: range and step bounds across consecutive queued values
    prev_y = 210;
    for (int c = 0; c < 10000; c++) begin
      bus.enable  = 1'($urandom_range(0, 1));
      bus.pop     = 1'($urandom_range(0, 1));
      bus.rand_in = $urandom;
      #2;
      if (bus.pop && bus.gap_valid) begin
        y = int'(bus.gap_y);
        diff = (y > prev_y) ? (y - prev_y) : (prev_y - y);
        chk("rnd_range", (y >= 80 && y <= 399), 1);
        chk("rnd_step",  (diff <= 120), 1);
        prev_y = y;
      end
      if (bus.level > 4) chk("rnd_overflow", bus.level, 4);
      tick();
    end

    // drain, then reset with level=3 and a sample in flight
    bus.enable = 1'b0; bus.pop = 1'b1;
    guard = 0;
    while (bus.level != 0 && guard < 10) begin tick(); guard++; end
    bus.pop = 1'b0;
    chk("pre_rst_drain", bus.level, 0);
    tick(2);
    bus.enable = 1'b1; bus.rand_in = 32'd5;
    tick(4);
    chk("pre_rst_level", bus.level, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    bus.enable = 1'b0;
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_valid", bus.gap_valid, 0);
    chk("mid_rst_rej",   bus.reject_cnt, 0);
    tick(2);
    chk("mid_rst_stale", bus.level, 0);
    bus.enable = 1'b1; bus.rand_in = 32'd319;
    tick();
    bus.enable = 1'b0;
    tick();
    chk("post_rst_first", bus.gap_y, 399);
    chk("post_rst_level", bus.level, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
